// File: rtl/nfu_pipe_ctrl_if.sv
// Control/status bundle between the NFU layer sequencer and its host/memory side.
// slave = sequencer side, master = host side.
interface nfu_pipe_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
);
  logic              i_start;
  logic              i_mode_max;
  logic [CNT_W-1:0]  i_num_in;
  logic [CNT_W-1:0]  i_num_out;
  logic              i_stall;

  logic              o_busy;
  logic              o_done;
  logic              o_op;
  logic              o_acc_clr;
  logic              o_nbin_rd_en;
  logic [ADDR_W-1:0] o_nbin_addr;
  logic              o_sb_rd_en;
  logic [ADDR_W-1:0] o_sb_addr;
  logic              o_nbout_rd_en;
  logic [ADDR_W-1:0] o_nbout_rd_addr;
  logic              o_nbout_wr_en;
  logic [ADDR_W-1:0] o_nbout_wr_addr;
  logic [31:0]       o_stall_cycles;

  modport slave (
    input  i_start, i_mode_max, i_num_in, i_num_out, i_stall,
    output o_busy, o_done, o_op, o_acc_clr,
           o_nbin_rd_en, o_nbin_addr, o_sb_rd_en, o_sb_addr,
           o_nbout_rd_en, o_nbout_rd_addr, o_nbout_wr_en, o_nbout_wr_addr,
           o_stall_cycles
  );

  modport master (
    output i_start, i_mode_max, i_num_in, i_num_out, i_stall,
    input  o_busy, o_done, o_op, o_acc_clr,
           o_nbin_rd_en, o_nbin_addr, o_sb_rd_en, o_sb_addr,
           o_nbout_rd_en, o_nbout_rd_addr, o_nbout_wr_en, o_nbout_wr_addr,
           o_stall_cycles
  );
endinterface

// File: rtl/nfu_pipe_ctrl.sv
// NFU layer sequencer: issues NBin/SB/NBout reads input-tile-outer, ages NBout writes by PIPE_LAT.
// Optional stall-cycle counter enabled by defining NFU_CTRL_PERF_EN.
module nfu_pipe_ctrl #(
  parameter int PIPE_LAT = 6,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  nfu_pipe_ctrl_if.slave   io_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int               GAP_W   = $clog2(PIPE_LAT + 2);
  localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(PIPE_LAT + 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic [CNT_W-1:0]  r_i;
  logic [CNT_W-1:0]  r_o;
  logic [CNT_W-1:0]  r_num_in;
  logic [CNT_W-1:0]  r_num_out;
  logic [ADDR_W-1:0] r_sb_addr;
  logic              r_mode;
  logic [GAP_W-1:0]  r_gap;
  logic [PIPE_LAT-1:0] r_wr_v;
  logic [ADDR_W-1:0] r_wr_a [PIPE_LAT];

  logic              w_start_ok;
  logic              w_zero;
  logic              w_hazard;
  logic              w_issue;
  logic              w_last_o;
  logic              w_last;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_start_ok = (r_state == S_IDLE) && io_bus.i_start;
  assign w_zero     = (io_bus.i_num_in == '0) || (io_bus.i_num_out == '0);
  // A new pass must wait until the previous pass's first partial sum has been written back.
  assign w_hazard   = (r_o == '0) && (r_i != '0) && (r_gap < GAP_MIN);
  assign w_issue    = (r_state == S_ISSUE) && !io_bus.i_stall && !w_hazard;
  assign w_last_o   = (r_o == (r_num_out - CNT_W'(1)));
  assign w_last     = w_last_o && (r_i == (r_num_in - CNT_W'(1)));
  assign w_rd_addr  = w_issue ? ADDR_W'(r_o) : '0;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_d = w_zero ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_issue && w_last) w_state_d = S_DRAIN;
      S_DRAIN: if (r_wr_v == '0) w_state_d = S_DONE;
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_o       <= '0;
      r_num_in  <= '0;
      r_num_out <= '0;
      r_sb_addr <= '0;
      r_mode    <= 1'b0;
      r_gap     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start_ok) begin
        r_num_in  <= io_bus.i_num_in;
        r_num_out <= io_bus.i_num_out;
        r_mode    <= io_bus.i_mode_max;
        r_i       <= '0;
        r_o       <= '0;
        r_sb_addr <= '0;
      end else if (w_issue) begin
        if (w_last_o) begin
          r_o       <= '0;
          r_i       <= r_i + CNT_W'(1);
          r_sb_addr <= ADDR_W'(r_i) + ADDR_W'(1);
        end else begin
          r_o       <= r_o + CNT_W'(1);
          r_sb_addr <= r_sb_addr + ADDR_W'(r_num_in);
        end
      end
      // Cycles elapsed since the first issue of the current pass, saturating at GAP_MIN.
      if (w_start_ok) begin
        r_gap <= '0;
      end else if (w_issue && (r_o == '0)) begin
        r_gap <= GAP_W'(1);
      end else if (r_gap < GAP_MIN) begin
        r_gap <= r_gap + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_v <= '0;
      for (int k = 0; k < PIPE_LAT; k++) r_wr_a[k] <= '0;
    end else begin
      r_wr_v[0] <= w_issue;
      r_wr_a[0] <= w_rd_addr;
      for (int k = 1; k < PIPE_LAT; k++) begin
        r_wr_v[k] <= r_wr_v[k-1];
        r_wr_a[k] <= r_wr_a[k-1];
      end
    end
  end

  assign io_bus.o_busy          = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign io_bus.o_done          = (r_state == S_DONE);
  assign io_bus.o_op            = r_mode;
  assign io_bus.o_acc_clr       = w_issue && (r_i == '0);
  assign io_bus.o_nbin_rd_en    = w_issue;
  assign io_bus.o_nbin_addr     = w_issue ? ADDR_W'(r_i) : '0;
  assign io_bus.o_sb_rd_en      = w_issue;
  assign io_bus.o_sb_addr       = w_issue ? r_sb_addr : '0;
  assign io_bus.o_nbout_rd_en   = w_issue;
  assign io_bus.o_nbout_rd_addr = w_rd_addr;
  assign io_bus.o_nbout_wr_en   = r_wr_v[PIPE_LAT-1];
  assign io_bus.o_nbout_wr_addr = r_wr_a[PIPE_LAT-1];

`ifdef NFU_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ISSUE) && !w_issue && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign io_bus.o_stall_cycles = r_stall_cnt;
`else
  assign io_bus.o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_nfu_pipe_ctrl.sv
// Scoreboard bench for nfu_pipe_ctrl: the stimulus side drives layers, the monitor side
// derives the expected issue/write streams from the tiling rules and compares each cycle.
module tb_nfu_pipe_ctrl;
  localparam int PIPE_LAT = 6;
  localparam int CNT_W    = 8;
  localparam int ADDR_W   = 16;
  localparam int NEVER    = 32'h7fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  nfu_pipe_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  nfu_pipe_ctrl #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int i; int o; logic [ADDR_W-1:0] sb; } iss_t;
  typedef struct { int c; logic [ADDR_W-1:0] a; } wr_t;

  iss_t   m_iss[$];
  wr_t    m_wr[$];
  int     m_start_ok   = 0;
  int     m_start_cyc  = 0;
  int     m_pass_first = 0;
  int     m_done_cyc   = -1;
  bit     m_layer_nz   = 1'b0;
  logic   m_mode       = 1'b0;
  longint m_stall      = 0;

  int     n_tests = 0;
  int     n_fail  = 0;

  bit     mon_active, mon_exp_iss, mon_exp_wr;
  iss_t   mon_f;
  iss_t   mon_r;
  wr_t    mon_w;
  int     mon_nin, mon_nout;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.o_busy, bus.o_done, bus.o_op, bus.o_acc_clr, bus.o_nbin_rd_en,
                         bus.o_sb_rd_en, bus.o_nbout_rd_en, bus.o_nbout_wr_en}, 0);
    chk({tag, "_addr_rd"}, {bus.o_nbin_addr, bus.o_sb_addr, bus.o_nbout_rd_addr}, 0);
    chk({tag, "_addr_wr"}, bus.o_nbout_wr_addr, 0);
    chk({tag, "_stall"}, bus.o_stall_cycles, 0);
  endtask

  // Monitor / reference model: the layer is a list of (i, o) tiles in i-outer order; one is
  // retired per cycle unless stalled or the next pass would start too soon after the previous.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_iss.delete();
      m_wr.delete();
      m_done_cyc = -1;
      m_layer_nz = 1'b0;
      m_mode     = 1'b0;
      m_stall    = 0;
    end else begin
`ifdef NFU_CTRL_PERF_EN
      chk("stall_cycles", bus.o_stall_cycles, m_stall);
`else
      chk("stall_cycles", bus.o_stall_cycles, 0);
`endif
      mon_active  = m_layer_nz && (cyc >= m_start_ok) && (m_iss.size() > 0);
      mon_exp_iss = 1'b0;
      if (mon_active && !bus.i_stall) begin
        mon_f = m_iss[0];
        mon_exp_iss = (mon_f.o != 0) || (mon_f.i == 0) ||
                      (cyc >= m_pass_first + PIPE_LAT + 1);
      end
      chk("nbin_rd_en", bus.o_nbin_rd_en, mon_exp_iss);
      chk("sb_rd_en", bus.o_sb_rd_en, mon_exp_iss);
      chk("nbout_rd_en", bus.o_nbout_rd_en, mon_exp_iss);
      if (mon_exp_iss) begin
        mon_f = m_iss.pop_front();
        chk("nbin_addr", bus.o_nbin_addr, mon_f.i);
        chk("sb_addr", bus.o_sb_addr, mon_f.sb);
        chk("nbout_rd_addr", bus.o_nbout_rd_addr, mon_f.o);
        chk("acc_clr", bus.o_acc_clr, (mon_f.i == 0));
        if (mon_f.o == 0) m_pass_first = cyc;
        mon_w.c = cyc + PIPE_LAT;
        mon_w.a = ADDR_W'(mon_f.o);
        m_wr.push_back(mon_w);
        if (m_iss.size() == 0) m_done_cyc = cyc + PIPE_LAT + 2;
      end else begin
        chk("idle_rd_outs", {bus.o_acc_clr, bus.o_nbin_addr, bus.o_sb_addr,
                             bus.o_nbout_rd_addr}, 0);
        if (mon_active) m_stall++;
      end

      mon_exp_wr = (m_wr.size() > 0) && (m_wr[0].c == cyc);
      chk("nbout_wr_en", bus.o_nbout_wr_en, mon_exp_wr);
      if (mon_exp_wr) begin
        mon_w = m_wr.pop_front();
        chk("nbout_wr_addr", bus.o_nbout_wr_addr, mon_w.a);
      end else begin
        chk("idle_wr_addr", bus.o_nbout_wr_addr, 0);
      end

      chk("done", bus.o_done, (cyc == m_done_cyc));
      chk("busy", bus.o_busy, m_layer_nz && (cyc > m_start_cyc) && (cyc < m_done_cyc));
      chk("op", bus.o_op, m_mode);

      if (bus.i_start && (cyc > m_done_cyc)) begin
        mon_nin     = int'(bus.i_num_in);
        mon_nout    = int'(bus.i_num_out);
        m_mode      = bus.i_mode_max;
        m_stall     = 0;
        m_start_cyc = cyc;
        m_start_ok  = cyc + 1;
        if (mon_nin == 0 || mon_nout == 0) begin
          m_layer_nz = 1'b0;
          m_done_cyc = cyc + 1;
        end else begin
          m_layer_nz = 1'b1;
          m_done_cyc = NEVER;
          for (int i = 0; i < mon_nin; i++) begin
            for (int o = 0; o < mon_nout; o++) begin
              mon_r.i  = i;
              mon_r.o  = o;
              mon_r.sb = ADDR_W'(o * mon_nin + i);
              m_iss.push_back(mon_r);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // prob: random stall percentage; stall forced for st_len cycles from st_from;
  // inj_at: cycle offset at which a conflicting start is pulsed mid-layer (-1 = none).
  task automatic run_layer(input int nin, input int nout, input bit mode, input int prob,
                           input int st_from, input int st_len, input int inj_at);
    bit seen;
    int k;
    bus.i_num_in   = CNT_W'(nin);
    bus.i_num_out  = CNT_W'(nout);
    bus.i_mode_max = mode;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 3000) begin
      bus.i_stall = ($urandom_range(99) < prob) || (k >= st_from && k < st_from + st_len);
      if (k == inj_at) begin
        bus.i_start    = 1'b1;
        bus.i_num_in   = CNT_W'(1);
        bus.i_num_out  = CNT_W'(1);
        bus.i_mode_max = !mode;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
      tick();
      k++;
    end
    bus.i_stall = 1'b0;
    bus.i_start = 1'b0;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL layer_timeout nin=%0d nout=%0d got=no_done want=done", nin, nout);
    end
  endtask

  task automatic reset_in_drain();
    int k;
    bus.i_num_in   = CNT_W'(2);
    bus.i_num_out  = CNT_W'(3);
    bus.i_mode_max = 1'b1;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start = 1'b0;
    k = 0;
    while ((m_iss.size() != 0 || !m_layer_nz) && k < 200) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout got=issuing want=drain");
    end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_mode_max = 1'b0;
    bus.i_num_in   = '0;
    bus.i_num_out  = '0;
    bus.i_stall    = 1'b0;
    #1;
    chk_all_zero("rst_init");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    run_layer(2, 8, 1'b0, 0, -1, 0, -1);
    run_layer(3, 2, 1'b1, 0, -1, 0, -1);
    run_layer(0, 4, 1'b0, 0, -1, 0, -1);
    run_layer(4, 0, 1'b1, 0, -1, 0, -1);
    run_layer(2, 8, 1'b0, 0, 4, 4, -1);
    run_layer(4, 5, 1'b1, 0, -1, 0, 3);
    reset_in_drain();
    run_layer(1, 1, 1'b0, 0, -1, 0, -1);
    for (int n = 0; n < 14; n++) begin
      run_layer(int'($urandom_range(4)), int'($urandom_range(9)), 1'($urandom_range(1)),
                int'($urandom_range(40)), -1, 0, -1);
      repeat (int'($urandom_range(2))) tick();
    end
    repeat (PIPE_LAT + 3) tick();
    chk("iss_left", m_iss.size(), 0);
    chk("wr_left", m_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nfu_pipe_ctrl.md
NFU_PIPE_CTRL -- requirements
Module: nfu_pipe_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 6, meaning issue-to-NBout-write latency of the NFU-1/NFU-2 pipeline (3 NFU-1 + 1 pipe reg + 2 NFU-2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning tile-count width; ADDR_W, default 16, meaning SRAM address width.
REQ-003 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have i_start input 1 (start a layer); i_mode_max input 1 (1 = max, 0 = add); i_num_in input CNT_W (input tiles); i_num_out input CNT_W (output tiles); i_stall input 1 (NBin/SB not ready).
REQ-005 SHALL have outputs o_busy 1; o_done 1; o_op 1 (drives NFU-2 i_op); o_acc_clr 1 (forces NBout partial-sum operand to zero).
REQ-006 SHALL have outputs o_nbin_rd_en 1, o_nbin_addr ADDR_W, o_sb_rd_en 1, o_sb_addr ADDR_W, o_nbout_rd_en 1, o_nbout_rd_addr ADDR_W, o_nbout_wr_en 1, o_nbout_wr_addr ADDR_W, o_stall_cycles 32.

Function
REQ-007 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-008 IDLE -> ISSUE on i_start when both counts nonzero; IDLE -> DONE on i_start with either count zero (no issues, no writes).
REQ-009 i_start SHALL be ignored outside IDLE; counts and i_mode_max are latched on accepted start; o_op holds the latched mode until the next accepted start.
REQ-010 Issue order SHALL be input-tile outer (i), output-tile inner (o); one issue per cycle at most.
REQ-011 Per issue: o_nbin_rd_en = o_sb_rd_en = o_nbout_rd_en = 1; o_nbin_addr = i; o_sb_addr = o*num_in + i; o_nbout_rd_addr = o; o_acc_clr = (i == 0); all combinational from state, all-zero when not issuing.
REQ-012 No issue in a cycle with i_stall = 1; counters hold.
REQ-013 Hazard rule: the first issue (o = 0) of pass i > 0 SHALL occur no earlier than PIPE_LAT+1 cycles after the first issue of pass i-1; bubble cycles are inserted otherwise (relevant when num_out < PIPE_LAT+1).
REQ-014 o_nbout_wr_en and o_nbout_wr_addr SHALL equal the issue valid/o_nbout_rd_addr delayed exactly PIPE_LAT cycles via a shift register that runs regardless of i_stall or state.
REQ-015 After the issue with i = num_in-1, o = num_out-1: ISSUE -> DRAIN; DRAIN -> DONE when the write shift register holds no valid entries.
REQ-016 DONE SHALL last one cycle with o_done = 1, then -> IDLE; o_busy = 1 in ISSUE and DRAIN only.
REQ-017 Address arithmetic SHALL be unsigned, truncated to ADDR_W.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, clear counters, shift register, latched mode and o_stall_cycles; all outputs 0.
REQ-019 Reset mid-layer SHALL discard all pending writes; no o_nbout_wr_en after reset release until a new issue ages PIPE_LAT cycles.

Configuration
REQ-020 With NFU_CTRL_PERF_EN defined, o_stall_cycles SHALL count ISSUE-state cycles without an issue (stall or hazard bubble), clear on accepted start, saturate at 2^32-1.
REQ-021 Without NFU_CTRL_PERF_EN, o_stall_cycles SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-022 num_in=2, num_out=8, no stall -> 16 consecutive issues, sb_addr sequence 0,2,4..14,1,3..15, acc_clr high for first 8, last write 6 cycles after last issue, o_done one pulse.
REQ-023 num_in=3, num_out=2 -> pass starts spaced exactly 7 cycles, 5 bubbles per pass, o_stall_cycles=10 (PERF_EN).
REQ-024 num_in=0, num_out=4, start -> o_done next cycle, no rd_en/wr_en ever asserted.
REQ-025 i_stall high 4 cycles mid-pass -> issue stream pauses, addresses unchanged on resume, each write exactly 6 cycles after its issue.
REQ-026 rst_n low during DRAIN with 3 writes pending -> outputs 0 immediately, no wr_en after release; i_start during ISSUE -> ignored.
